// File: rtl/qbcd_pkg.sv
// Shared types and constants for the binary-to-BCD quotient converter.
package qbcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int           BCD_W      = 4;
   localparam logic [3:0]   ADJ_THRESH = 4'd5;
   localparam logic [3:0]   ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit holding 5 or more.
module bcd_digit_adj
   import qbcd_pkg::*;
(
   input  logic [BCD_W-1:0] d,
   output logic [BCD_W-1:0] q
);

   assign q = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;

endmodule

// File: rtl/quotient_bcd_conv.sv
// Sequential double-dabble converter: one binary bit per cycle, WIDTH cycles per result.
// Optional QBCD_LEADING_ZERO_BLANK_EN adds a digit_en output for leading-zero blanking.
module quotient_bcd_conv
   import qbcd_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          bin_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BCD_W*DIGITS-1:0]   bcd_out
`ifdef QBCD_LEADING_ZERO_BLANK_EN
   ,
   output logic [DIGITS-1:0]         digit_en
`endif
);

   localparam int                BCD_TOT = BCD_W * DIGITS;
   localparam int                CNT_W   = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST    = CNT_W'(WIDTH - 1);

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     bin_sr;
   logic [BCD_TOT-1:0]   bcd_work;
   logic [BCD_TOT-1:0]   bcd_adj;
   logic [BCD_TOT-1:0]   bcd_shifted;
   logic [BCD_TOT-1:0]   bcd_q;
   logic [CNT_W-1:0]     cnt;
   logic                 last_shift;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .d (bcd_work[g*BCD_W +: BCD_W]),
            .q (bcd_adj[g*BCD_W +: BCD_W])
         );
      end
   endgenerate

   // The top BCD bit falls off the end; DIGITS is sized so it is always zero.
   assign bcd_shifted = BCD_TOT'({bcd_adj, bin_sr[WIDTH-1]});
   assign last_shift  = (cnt == LAST);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last_shift) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Working registers are separate from bcd_q so partial results never reach bcd_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bin_sr   <= '0;
         bcd_work <= '0;
         bcd_q    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  bin_sr   <= bin_in;
                  bcd_work <= '0;
                  cnt      <= '0;
               end
            end
            SHIFT: begin
               bcd_work <= bcd_shifted;
               bin_sr   <= {bin_sr[WIDTH-2:0], 1'b0};
               cnt      <= cnt + 1'b1;
               if (last_shift) bcd_q <= bcd_shifted;
            end
            default: ;
         endcase
      end
   end

   assign bcd_out = bcd_q;

`ifdef QBCD_LEADING_ZERO_BLANK_EN
   always_comb begin
      logic seen;
      seen     = 1'b0;
      digit_en = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (bcd_q[i*BCD_W +: BCD_W] != '0) seen = 1'b1;
         digit_en[i] = seen;
      end
      digit_en[0] = 1'b1;
   end
`endif

endmodule
